hamming_scrubber: RTL and testbench

HAMMING_SCRUBBER -- requirements
Module: hamming_scrubber

---
 rtl/hamming_scrubber.sv | 214 +++++++++++++++++++++
 tb/tb_hamming_scrubber.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_scrubber.sv
// hamming_scrubber: periodically freezes a SECDED-protected counter stage,
// samples its stored word, decodes Hamming(21,16)+parity and writes back a
// corrected word when a single-bit error is found.
module hamming_scrubber #(
    parameter int SCRUB_PERIOD = 64,
    parameter int ACK_TIMEOUT  = 16,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             hold_req,
    input  logic             hold_ack,
    input  logic [15:0]      data_in,
    input  logic [5:0]       chk_in,
    output logic             wr_en,
    output logic [15:0]      data_out,
    output logic [5:0]       chk_out,
    output logic             sec_err,
    output logic             ded_err,
    output logic [4:0]       err_pos,
    output logic [CNT_W-1:0] sec_count,
    output logic [CNT_W-1:0] ded_count,
    input  logic             clr_counts,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE, REQ, SAMPLE, DECODE, WRITE, RELEASE
    } state_t;

    // REQ waits ACK_TIMEOUT cycles, so the wait counter runs 0..ACK_TIMEOUT-1
    localparam int               ACK_W      = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [15:0]      TIMER_LAST = 16'(SCRUB_PERIOD - 1);
    localparam logic [ACK_W-1:0] ACK_LAST   = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    // Data bit index that lands on code position pos (positions 3,5,6,7,9.. in order)
    function automatic int data_index(input int pos);
        int idx;
        idx = 0;
        for (int p = 3; p < pos; p++) begin
            if ((p & (p - 1)) != 0) idx++;
        end
        return idx;
    endfunction

    state_t             state_reg, state_next;
    logic [15:0]        timer_reg, timer_next;
    logic [ACK_W-1:0]   ack_cnt_reg, ack_cnt_next;

    logic [15:0]        samp_data_reg;
    logic [5:0]         samp_chk_reg;
    logic [4:0]         syn_reg;
    logic               par_reg;
    logic [15:0]        data_out_reg;
    logic [5:0]         chk_out_reg;
    logic [4:0]         err_pos_reg;
    logic [CNT_W-1:0]   sec_count_reg;
    logic [CNT_W-1:0]   ded_count_reg;

    logic [21:0]        code_word;
    logic [21:0]        flip_vec;
    logic [21:0]        corr_word;
    logic [15:0]        corr_data;
    logic [5:0]         corr_chk;
    logic [4:0]         syn_calc;
    logic               par_calc;
    logic               single_calc;
    logic               res_single;
    logic               res_double;
    logic               in_write;

    // Position 0 carries the overall parity bit; 1..21 are the Hamming positions.
    assign code_word[0] = samp_chk_reg[5];
    assign corr_chk[5]  = corr_word[0];

    generate
        for (genvar gi = 1; gi < 22; gi++) begin : g_pos
            if ((gi & (gi - 1)) == 0) begin : g_chk
                localparam int CI = $clog2(gi);
                assign code_word[gi] = samp_chk_reg[CI];
                assign corr_chk[CI]  = corr_word[gi];
            end else begin : g_data
                localparam int DI = data_index(gi);
                assign code_word[gi]  = samp_data_reg[DI];
                assign corr_data[DI]  = corr_word[gi];
            end
        end
        // One-hot flip mask selecting the position named by the syndrome
        for (genvar gi = 0; gi < 22; gi++) begin : g_flip
            localparam logic [4:0] POS = 5'(gi);
            assign flip_vec[gi] = single_calc && (syn_calc == POS);
        end
    endgenerate

    assign corr_word = code_word ^ flip_vec;

    // Syndrome is the XOR of the indices of all set positions; parity covers all 22 bits
    always_comb begin
        syn_calc = '0;
        for (int i = 1; i < 22; i++) begin
            if (code_word[i]) syn_calc = syn_calc ^ 5'(i);
        end
        par_calc    = ^code_word;
        single_calc = par_calc && (syn_calc <= 5'd21);
    end

    // Classification of the registered syndrome; p=1 with s>21 counts as uncorrectable
    assign res_single = par_reg && (syn_reg <= 5'd21);
    assign res_double = !res_single && (par_reg || (syn_reg != 5'd0));
    assign in_write   = (state_reg == WRITE);

    // Next-state, idle timer and acknowledge-wait counter
    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg;
        ack_cnt_next = ack_cnt_reg;
        case (state_reg)
            IDLE: begin
                ack_cnt_next = '0;
                if (enable) begin
                    if (timer_reg == TIMER_LAST) begin
                        timer_next = '0;
                        state_next = REQ;
                    end else begin
                        timer_next = timer_reg + 16'd1;
                    end
                end
            end
            REQ: begin
                if (hold_ack) begin
                    state_next = SAMPLE;
                end else if (ack_cnt_reg == ACK_LAST) begin
                    state_next = IDLE;
                end else begin
                    ack_cnt_next = ack_cnt_reg + 1'b1;
                end
            end
            SAMPLE:  state_next = DECODE;
            DECODE:  state_next = WRITE;
            WRITE:   state_next = RELEASE;
            RELEASE: if (!hold_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, timer and wait-counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            timer_reg   <= '0;
            ack_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            ack_cnt_reg <= ack_cnt_next;
        end
    end

    // Sample the frozen word, register the decode, and keep the last corrected word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            samp_data_reg <= '0;
            samp_chk_reg  <= '0;
            syn_reg       <= '0;
            par_reg       <= 1'b0;
            data_out_reg  <= '0;
            chk_out_reg   <= '0;
            err_pos_reg   <= '0;
        end else begin
            if (state_reg == SAMPLE) begin
                samp_data_reg <= data_in;
                samp_chk_reg  <= chk_in;
            end
            if (state_reg == DECODE) begin
                syn_reg <= syn_calc;
                par_reg <= par_calc;
                if (single_calc) begin
                    data_out_reg <= corr_data;
                    chk_out_reg  <= corr_chk;
                end
            end
            if (in_write && res_single) err_pos_reg <= syn_reg;
        end
    end

    // Saturating event counters; a clear beats a coincident event
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sec_count_reg <= '0;
            ded_count_reg <= '0;
        end else if (clr_counts) begin
            sec_count_reg <= '0;
            ded_count_reg <= '0;
        end else begin
            if (sec_err && (sec_count_reg != CNT_MAX)) sec_count_reg <= sec_count_reg + 1'b1;
            if (ded_err && (ded_count_reg != CNT_MAX)) ded_count_reg <= ded_count_reg + 1'b1;
        end
    end

    assign hold_req  = (state_reg == REQ) || (state_reg == SAMPLE) ||
                       (state_reg == DECODE) || (state_reg == WRITE);
    assign busy      = (state_reg != IDLE);
    assign wr_en     = in_write && res_single;
    assign sec_err   = in_write && res_single;
    assign ded_err   = in_write && res_double;
    assign err_pos   = (in_write && res_single) ? syn_reg : err_pos_reg;
    assign data_out  = data_out_reg;
    assign chk_out   = chk_out_reg;
    assign sec_count = sec_count_reg;
    assign ded_count = ded_count_reg;

endmodule

// File: tb/tb_hamming_scrubber.sv
// Self-checking bench for hamming_scrubber: directed cases plus randomized
// passes checked against a behavioural SECDED model.
`timescale 1ns/1ps
module tb_hamming_scrubber;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        hold_req;
    logic        hold_ack;
    logic [15:0] data_in;
    logic [5:0]  chk_in;
    logic        wr_en;
    logic [15:0] data_out;
    logic [5:0]  chk_out;
    logic        sec_err;
    logic        ded_err;
    logic [4:0]  err_pos;
    logic [7:0]  sec_count;
    logic [7:0]  ded_count;
    logic        clr_counts;
    logic        busy;

    always #5 clk = ~clk;

    hamming_scrubber dut (
        .clk(clk), .reset(reset), .enable(enable), .hold_req(hold_req),
        .hold_ack(hold_ack), .data_in(data_in), .chk_in(chk_in), .wr_en(wr_en),
        .data_out(data_out), .chk_out(chk_out), .sec_err(sec_err), .ded_err(ded_err),
        .err_pos(err_pos), .sec_count(sec_count), .ded_count(ded_count),
        .clr_counts(clr_counts), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // expected architectural state
    int          exp_sec, exp_ded;
    logic [15:0] exp_dout;
    logic [5:0]  exp_cout;
    logic [4:0]  exp_pos;

    // results captured by run_pass
    int   r_wait;
    bit   r_ok, r_stray, r_wr, r_sec, r_ded, r_hreq_w, r_hreq_rel, r_busy_rel, r_busy_idle;
    logic [4:0]  r_pos;
    logic [15:0] r_dout;
    logic [5:0]  r_cout;

    // Check bits that make a data word a valid codeword
    function automatic logic [5:0] encode(input logic [15:0] d);
        int s, di;
        logic [5:0] c;
        s = 0; di = 0;
        for (int pos = 1; pos < 22; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (d[di]) s = s ^ pos;
                di++;
            end
        end
        c[4:0] = s[4:0];
        c[5]   = (^d) ^ (^c[4:0]);
        return c;
    endfunction

    // Reference decode: kind 0 clean, 1 single (corrected), 2 double/uncorrectable
    function automatic void model(input logic [15:0] d, input logic [5:0] c, output int kind,
                                  output logic [4:0] pos, output logic [15:0] cd, output logic [5:0] cc);
        logic b[22];
        int s, p, di, ci;
        b[0] = c[5]; di = 0; ci = 0;
        for (int i = 1; i < 22; i++) begin
            if ((i & (i - 1)) == 0) begin b[i] = c[ci]; ci++; end
            else begin b[i] = d[di]; di++; end
        end
        s = 0; p = 0;
        for (int i = 0; i < 22; i++) if (b[i]) begin s = s ^ i; p = p ^ 1; end
        if (s == 0 && p == 0) kind = 0;
        else if (p == 1 && s <= 21) kind = 1;
        else kind = 2;
        if (kind == 1) b[s] = ~b[s];
        di = 0; ci = 0;
        cc[5] = b[0];
        for (int i = 1; i < 22; i++) begin
            if ((i & (i - 1)) == 0) begin cc[ci] = b[i]; ci++; end
            else begin cd[di] = b[i]; di++; end
        end
        pos = s[4:0];
    endfunction

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    // Act as the protected counter stage for one scrub pass and capture what the DUT shows
    task automatic run_pass(input logic [15:0] d, input logic [5:0] c, input int ack_delay,
                            input int rel_delay, input bit clr_at_write, input bit drop_en);
        r_ok = 1; r_wait = 0; r_stray = 0;
        while (hold_req !== 1'b1 && r_wait < 400) begin @(posedge clk); #1; r_wait++; end
        if (hold_req !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL hold_req_wait: hold_req=%b after %0d cycles, required 1", hold_req, r_wait);
            r_ok = 0;
            return;
        end
        for (int i = 0; i < ack_delay; i++) begin @(posedge clk); #1; end
        data_in = d; chk_in = c; hold_ack = 1'b1;
        @(posedge clk); #1;
        if (drop_en) enable = 1'b0;
        if (wr_en || sec_err || ded_err) r_stray = 1;
        @(posedge clk); #1;
        if (wr_en || sec_err || ded_err) r_stray = 1;
        @(posedge clk); #1;
        r_wr = wr_en; r_sec = sec_err; r_ded = ded_err; r_pos = err_pos;
        r_dout = data_out; r_cout = chk_out; r_hreq_w = hold_req;
        if (clr_at_write) clr_counts = 1'b1;
        @(posedge clk); #1;
        clr_counts = 1'b0;
        r_hreq_rel = hold_req;
        if (wr_en || sec_err || ded_err) r_stray = 1;
        for (int i = 0; i < rel_delay; i++) begin @(posedge clk); #1; end
        r_busy_rel = busy;
        hold_ack = 1'b0;
        data_in = 16'($urandom); chk_in = 6'($urandom);
        @(posedge clk); #1;
        r_busy_idle = busy;
    endtask

    task automatic test_reset;
        reset = 1'b0; enable = 1'b0; hold_ack = 1'b0; data_in = '0; chk_in = '0; clr_counts = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({hold_req, wr_en, sec_err, ded_err, busy} !== 5'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b required 00000", {hold_req, wr_en, sec_err, ded_err, busy});
        end
        n_cmp++;
        if ({data_out, chk_out, err_pos} !== 27'b0) begin
            n_bad++; $display("FAIL reset_data: got %h/%h/%0d required 0/0/0", data_out, chk_out, err_pos);
        end
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if ({sec_count, ded_count, busy, hold_req} !== 18'b0) begin
            n_bad++; $display("FAIL reset_idle: counts %0d/%0d busy %b hold_req %b, required all 0", sec_count, ded_count, busy, hold_req);
        end
        exp_sec = 0; exp_ded = 0; exp_dout = '0; exp_cout = '0; exp_pos = '0;
        $display("reset: done");
    endtask

    task automatic test_clean;
        enable = 1'b1;
        run_pass(16'h0000, 6'h00, 0, 3, 0, 0);
        n_cmp++;
        if (r_wait != 64) begin n_bad++; $display("FAIL clean_period: hold_req after %0d cycles, required 64", r_wait); end
        n_cmp++;
        if ({r_wr, r_sec, r_ded, r_stray} !== 4'b0) begin
            n_bad++; $display("FAIL clean_flags: wr/sec/ded/stray %b required 0000", {r_wr, r_sec, r_ded, r_stray});
        end
        n_cmp++;
        if ({r_hreq_w, r_hreq_rel, r_busy_rel, r_busy_idle} !== 4'b1010) begin
            n_bad++; $display("FAIL clean_handshake: hreq_write/hreq_rel/busy_rel/busy_idle %b required 1010", {r_hreq_w, r_hreq_rel, r_busy_rel, r_busy_idle});
        end
        n_cmp++;
        if ({r_dout, r_cout} !== 22'b0) begin n_bad++; $display("FAIL clean_hold: data_out %h chk_out %h required 0/0", r_dout, r_cout); end
        $display("clean: wait=%0d wr=%b", r_wait, r_wr);
    endtask

    task automatic test_data_sec;
        run_pass(16'h0001, 6'h00, 0, 0, 0, 0);
        exp_sec = sat(exp_sec); exp_pos = 5'd3;
        n_cmp++;
        if ({r_wr, r_sec, r_ded, r_stray, r_hreq_w} !== 5'b11001) begin
            n_bad++; $display("FAIL data_sec_flags: wr/sec/ded/stray/hreq %b required 11001", {r_wr, r_sec, r_ded, r_stray, r_hreq_w});
        end
        n_cmp++;
        if (r_pos !== 5'd3) begin n_bad++; $display("FAIL data_sec_pos: got %0d required 3", r_pos); end
        n_cmp++;
        if ({r_dout, r_cout} !== 22'b0) begin n_bad++; $display("FAIL data_sec_word: got %h/%h required 0000/00", r_dout, r_cout); end
        n_cmp++;
        if (sec_count !== 8'd1) begin n_bad++; $display("FAIL data_sec_count: got %0d required 1", sec_count); end
        $display("data_sec: pos=%0d dout=%h", r_pos, r_dout);
    endtask

    task automatic test_chk_sec;
        logic [5:0] chks [2];
        logic [4:0] poss [2];
        chks[0] = 6'h01; poss[0] = 5'd1;
        chks[1] = 6'h20; poss[1] = 5'd0;
        for (int k = 0; k < 2; k++) begin
            run_pass(16'h0000, chks[k], 1, 0, 0, 0);
            exp_sec = sat(exp_sec); exp_pos = poss[k];
            n_cmp++;
            if ({r_wr, r_sec, r_ded, r_pos, r_cout} !== {3'b110, poss[k], 6'h00}) begin
                n_bad++; $display("FAIL chk_sec_%0d: wr/sec/ded %b pos %0d chk_out %h, required 110 pos %0d chk_out 00", k, {r_wr, r_sec, r_ded}, r_pos, r_cout, poss[k]);
            end
            $display("chk_sec: chk_in=%h pos=%0d chk_out=%h", chks[k], r_pos, r_cout);
        end
        n_cmp++;
        if (sec_count !== 8'(exp_sec)) begin n_bad++; $display("FAIL chk_sec_count: got %0d required %0d", sec_count, exp_sec); end
    endtask

    task automatic test_ded;
        run_pass(16'h0003, 6'h00, 0, 0, 0, 0);
        exp_ded = sat(exp_ded);
        n_cmp++;
        if ({r_wr, r_sec, r_ded, r_stray} !== 4'b0010) begin
            n_bad++; $display("FAIL ded_flags: wr/sec/ded/stray %b required 0010", {r_wr, r_sec, r_ded, r_stray});
        end
        n_cmp++;
        if ({ded_count, sec_count} !== {8'd1, 8'(exp_sec)}) begin
            n_bad++; $display("FAIL ded_count: ded %0d sec %0d required 1/%0d", ded_count, sec_count, exp_sec);
        end
        n_cmp++;
        if ({r_dout, r_cout, r_pos} !== {exp_dout, exp_cout, exp_pos}) begin
            n_bad++; $display("FAIL ded_hold: got %h/%h/%0d required %h/%h/%0d", r_dout, r_cout, r_pos, exp_dout, exp_cout, exp_pos);
        end
        $display("ded: ded_err=%b ded_count=%0d", r_ded, ded_count);
    endtask

    task automatic test_timeout;
        int n, w;
        bit flags;
        hold_ack = 1'b0; w = 0; n = 0; flags = 0;
        while (hold_req !== 1'b1 && w < 400) begin @(posedge clk); #1; w++; end
        while (hold_req === 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
            if (wr_en || sec_err || ded_err) flags = 1;
        end
        n_cmp++;
        if (n != 16) begin n_bad++; $display("FAIL timeout_len: hold_req high %0d cycles, required 16", n); end
        n_cmp++;
        if ({flags, busy} !== 2'b00) begin n_bad++; $display("FAIL timeout_state: flags %b busy %b required 0 0", flags, busy); end
        n_cmp++;
        if ({sec_count, ded_count} !== {8'(exp_sec), 8'(exp_ded)}) begin
            n_bad++; $display("FAIL timeout_counts: got %0d/%0d required %0d/%0d", sec_count, ded_count, exp_sec, exp_ded);
        end
        $display("timeout: hold_req high %0d cycles", n);
    endtask

    task automatic test_enable_mid_pass;
        int n;
        bit seen;
        run_pass(16'h0100, 6'h00, 0, 0, 0, 1);
        exp_sec = sat(exp_sec); exp_pos = 5'd13; exp_dout = 16'h0000; exp_cout = 6'h00;
        n_cmp++;
        if ({r_wr, r_sec, r_pos, r_dout} !== {2'b11, 5'd13, 16'h0000}) begin
            n_bad++; $display("FAIL en_mid_pass: wr/sec %b pos %0d dout %h required 11 13 0000", {r_wr, r_sec}, r_pos, r_dout);
        end
        seen = 0;
        for (n = 0; n < 100; n++) begin @(posedge clk); #1; if (hold_req) seen = 1; end
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL en_off_hold: hold_req rose with enable low, required none"); end
        enable = 1'b1;
        $display("enable_mid_pass: wr=%b pos=%0d", r_wr, r_pos);
    endtask

    task automatic test_clr_counts;
        run_pass(16'h0001, 6'h00, 0, 0, 1, 0);
        exp_sec = 0; exp_ded = 0; exp_pos = 5'd3; exp_dout = '0; exp_cout = '0;
        n_cmp++;
        if ({r_sec, sec_count, ded_count} !== {1'b1, 16'h0000}) begin
            n_bad++; $display("FAIL clr_wins: sec %b counts %0d/%0d required 1 0/0", r_sec, sec_count, ded_count);
        end
        $display("clr_counts: sec_count=%0d", sec_count);
    endtask

    task automatic test_random_passes;
        logic [21:0] w;
        logic [15:0] cd;
        logic [5:0]  cc;
        logic [4:0]  pos;
        int kind, nerr;
        for (int t = 0; t < 40; t++) begin
            w[15:0]  = 16'($urandom);
            w[21:16] = encode(w[15:0]);
            nerr = $urandom_range(0, 3);
            for (int e = 0; e < nerr; e++) w[$urandom_range(0, 21)] ^= 1'b1;
            model(w[15:0], w[21:16], kind, pos, cd, cc);
            run_pass(w[15:0], w[21:16], $urandom_range(0, 4), $urandom_range(0, 2), 0, 0);
            if (kind == 1) begin exp_sec = sat(exp_sec); exp_dout = cd; exp_cout = cc; exp_pos = pos; end
            if (kind == 2) exp_ded = sat(exp_ded);
            n_cmp++;
            if ({r_wr, r_sec, r_ded, r_stray} !== {kind == 1, kind == 1, kind == 2, 1'b0}) begin
                n_bad++; $display("FAIL rand_flags[%0d]: word %h wr/sec/ded/stray %b required %b%b%b0", t, w, {r_wr, r_sec, r_ded, r_stray}, kind == 1, kind == 1, kind == 2);
            end
            n_cmp++;
            if ({r_dout, r_cout, r_pos} !== {exp_dout, exp_cout, exp_pos}) begin
                n_bad++; $display("FAIL rand_word[%0d]: word %h got %h/%h/%0d required %h/%h/%0d", t, w, r_dout, r_cout, r_pos, exp_dout, exp_cout, exp_pos);
            end
            n_cmp++;
            if ({sec_count, ded_count} !== {8'(exp_sec), 8'(exp_ded)}) begin
                n_bad++; $display("FAIL rand_counts[%0d]: got %0d/%0d required %0d/%0d", t, sec_count, ded_count, exp_sec, exp_ded);
            end
            $display("random[%0d]: word=%h kind=%0d wr=%b pos=%0d dout=%h", t, w, kind, r_wr, r_pos, r_dout);
        end
    endtask

    task automatic test_reset_mid;
        int w;
        bit seen;
        w = 0;
        while (hold_req !== 1'b1 && w < 400) begin @(posedge clk); #1; w++; end
        data_in = 16'h0001; chk_in = 6'h00; hold_ack = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++;
        if ({busy, hold_req} !== 2'b11) begin n_bad++; $display("FAIL rst_mid_pre: busy/hold_req %b required 11", {busy, hold_req}); end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({hold_req, wr_en, sec_err, ded_err, busy, data_out, chk_out, err_pos, sec_count, ded_count} !== 48'b0) begin
            n_bad++; $display("FAIL rst_mid_clear: hreq %b wr %b dout %h cout %h pos %0d counts %0d/%0d busy %b required all 0", hold_req, wr_en, data_out, chk_out, err_pos, sec_count, ded_count, busy);
        end
        @(posedge clk); #1;
        reset = 1'b1; hold_ack = 1'b0;
        seen = 0;
        repeat (6) begin @(posedge clk); #1; if (wr_en || sec_err || busy) seen = 1; end
        n_cmp++;
        if ({seen, sec_count} !== 9'b0) begin n_bad++; $display("FAIL rst_mid_after: activity %b sec_count %0d required 0 0", seen, sec_count); end
        exp_sec = 0; exp_ded = 0; exp_dout = '0; exp_cout = '0; exp_pos = '0;
        $display("reset_mid: busy=%b sec_count=%0d", busy, sec_count);
    endtask

    task automatic test_saturation;
        for (int t = 0; t < 300; t++) begin
            run_pass(16'h0001, 6'h00, 0, 0, 0, 0);
            exp_sec = sat(exp_sec);
        end
        n_cmp++;
        if (sec_count !== 8'd255) begin n_bad++; $display("FAIL sat_sec: got %0d required 255", sec_count); end
        n_cmp++;
        if ({r_wr, r_sec, ded_count} !== {2'b11, 8'(exp_ded)}) begin
            n_bad++; $display("FAIL sat_last: wr/sec %b ded %0d required 11 %0d", {r_wr, r_sec}, ded_count, exp_ded);
        end
        $display("saturation: 300 passes sec_count=%0d", sec_count);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean();
        test_data_sec();
        test_chk_sec();
        test_ded();
        test_timeout();
        test_enable_mid_pass();
        test_clr_counts();
        test_random_passes();
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
